cdc_hs_arbiter: RTL and testbench

- Source-side controller that shares one 4-phase req/ack clock-domain crossing among N_REQ local requesters.
- Arbitration is round-robin. The winner's data word is latched and presented on a single crossing bus. The handshake is sequenced against an asynchronous acknowledge, which is re-timed internally by a SYNC_STAGES flip-flop synchronizer.
- Sits in the clk domain, in front of the far-domain receiver.

---
 rtl/cdc_hs_arbiter.sv | 141 ++++++++++++++
 tb/tb_cdc_hs_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_arbiter.sv
// rtl/cdc_hs_arbiter.sv - round-robin arbiter sharing one 4-phase req/ack crossing among N_REQ requesters
// Optional handshake timeout: define HS_TIMEOUT_EN.
module cdc_hs_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DW             = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                en,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data_in,
    output logic [N_REQ-1:0]    grant,
    output logic                xfer_req,
    output logic [DW-1:0]       xfer_data,
    output logic [IW-1:0]       xfer_id,
    input  logic                ack_async,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          win;
    logic                   found;
    logic                   grant_ok;
    logic [DW-1:0]          win_data;
    logic                   hit;
    logic                   aborted;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) ack_sync_q <= '0;
        else       ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
    end
    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    // Search starts just past the last winner so every requester gets its turn.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Holding off while done is high guarantees one idle cycle between transfers.
    assign grant_ok = (state == IDLE) && en && !ack_sync && !done && found;
    assign grant    = grant_ok ? (N_REQ'(1) << win) : '0;
    assign win_data = data_in[int'(win)*DW +: DW];
    assign busy     = (state != IDLE);

`ifdef HS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wcnt;
    logic          err_q;

    assign hit = (wcnt == CW'(TIMEOUT_CYCLES - 1));
    assign err = err_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wcnt    <= '0;
            aborted <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                REQ: begin
                    wcnt    <= (ack_sync || hit) ? '0 : wcnt + 1'b1;
                    aborted <= !ack_sync && hit;
                    err_q   <= !ack_sync && hit;
                end
                REL: begin
                    wcnt  <= (!ack_sync || hit) ? '0 : wcnt + 1'b1;
                    err_q <= ack_sync && hit;
                end
                default: begin
                    wcnt    <= '0;
                    aborted <= 1'b0;
                end
            endcase
        end
    end
`else
    assign hit     = 1'b0;
    assign aborted = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            ptr       <= IW'(N_REQ - 1);
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            xfer_id   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        xfer_data <= win_data;
                        xfer_id   <= win;
                        ptr       <= win;
                        xfer_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (ack_sync || hit) begin
                        xfer_req <= 1'b0;
                        state    <= REL;
                    end
                end
                REL: begin
                    if (!ack_sync) begin
                        done  <= !aborted;
                        state <= IDLE;
                    end else if (hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// tb/tb_cdc_hs_arbiter.sv - self-checking bench for cdc_hs_arbiter
module tb_cdc_hs_arbiter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  grant;
    logic        xfer_req;
    logic [7:0]  xfer_data;
    logic [1:0]  xfer_id;
    logic        ack_async = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;
    int mon_bad = 0;
    int sb_q[$];

    cdc_hs_arbiter #(.N_REQ(4), .DW(8), .SYNC_STAGES(S), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_(rst_), .en(en), .req(req), .data_in(data_in),
        .grant(grant), .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_id(xfer_id),
        .ack_async(ack_async), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog act=running req=stopped");
        $fatal(1, "watchdog");
    end

    // Grants must only appear in IDLE and never more than one at a time.
    always @(negedge clk) begin
        if (rst_) begin
            if (grant != 4'b0 && busy) mon_bad++;
            if (!$onehot0(grant)) mon_bad++;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_id;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic ack_level);
        @(negedge clk);
        rst_ = 1'b0;
        req = '0;
        en = 1'b1;
        ack_async = ack_level;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", {28'b0, grant}, 0);
        chk("rst_xfer_req", {31'b0, xfer_req}, 0);
        chk("rst_xfer_data", {24'b0, xfer_data}, 0);
        chk("rst_xfer_id", {30'b0, xfer_id}, 0);
        chk("rst_busy_done_err", {29'b0, busy, done, err}, 0);
        rst_ = 1'b1;
    endtask

    task automatic wait_grant(output int got, output int cyc);
        int exp;
        cyc = 0;
        got = -1;
        #1;
        while (grant == 4'b0 && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (grant == 4'b0) begin
            chk("grant_timeout", 0, 1);
        end else begin
            for (int i = 0; i < 4; i++) if (grant[i]) got = i;
            if (sb_q.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                exp = sb_q.pop_front();
                chk("grant", {28'b0, grant}, 32'(1) << exp);
            end
        end
    endtask

    // Called in the first REQ cycle; acts as the far-side responder.
    task automatic handshake(input int exp_id, input logic [7:0] exp_data);
        int n;
        chk("xfer_req_up", {31'b0, xfer_req}, 1);
        chk("xfer_data", {24'b0, xfer_data}, {24'b0, exp_data});
        chk("xfer_id", {30'b0, xfer_id}, exp_id);
        chk("busy_req", {31'b0, busy}, 1);
        ack_async = 1'b1;
        n = 0;
        while (xfer_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_fall_lat", n, S + 1);
        ack_async = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_lat", n, S + 1);
        chk("no_grant_on_done", {28'b0, grant}, 0);
        chk("busy_done", {31'b0, busy}, 0);
        @(negedge clk);
        #1;
        chk("done_pulse", {31'b0, done}, 0);
    endtask

    initial begin
        int got, cyc, cnt;
        vecs[0] = '{4'b0100, 32'h11A52233, 2};
        vecs[1] = '{4'b1111, 32'h44332211, 3};
        vecs[2] = '{4'b0011, 32'h5A6B7C8D, 0};
        vecs[3] = '{4'b0011, 32'hDEADBEEF, 1};
        vecs[4] = '{4'b1001, 32'h01020304, 3};
        vecs[5] = '{4'b1000, 32'hF0E0D0C0, 3};
        vecs[6] = '{4'b0110, 32'h13579BDF, 1};

        do_reset(1'b0);
        foreach (vecs[i]) begin
            logic [31:0] d;
            d = vecs[i].data;
            data_in = d;
            req = vecs[i].req;
            sb_q.push_back(vecs[i].exp_id);
            wait_grant(got, cyc);
            @(negedge clk);
            #1;
            req = '0;
            handshake(vecs[i].exp_id, d[vecs[i].exp_id*8 +: 8]);
        end

        // Round-robin with all four requesting continuously.
        do_reset(1'b0);
        data_in = 32'hA3B2C1D0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] d;
            d = data_in;
            sb_q.push_back(k % 4);
            wait_grant(got, cyc);
            @(negedge clk);
            #1;
            handshake(k % 4, d[(k % 4)*8 +: 8]);
        end
        req = '0;

        // Acknowledge stuck high out of reset.
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        #1;
        req = 4'b0001;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (grant != 4'b0) cnt++;
        end
        chk("stuck_no_grant", cnt, 0);
        ack_async = 1'b0;
        sb_q.push_back(0);
        wait_grant(got, cyc);
        chk("stuck_grant_lat", {31'b0, cyc <= S + 2}, 1);
        @(negedge clk);
        #1;
        req = '0;
        handshake(0, data_in[7:0]);

        // Enable gating.
        do_reset(1'b0);
        data_in = 32'h9988_7766;
        en = 1'b0;
        req = 4'b0011;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (grant != 4'b0) cnt++;
        end
        chk("en0_no_grant", cnt, 0);
        en = 1'b1;
        sb_q.push_back(0);
        wait_grant(got, cyc);
        @(negedge clk);
        #1;
        en = 1'b0;
        handshake(0, 8'h66);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (grant != 4'b0) cnt++;
        end
        chk("en0_after_done", cnt, 0);
        en = 1'b1;
        sb_q.push_back(1);
        wait_grant(got, cyc);
        @(negedge clk);
        #1;
        req = '0;
        handshake(1, 8'h77);

        // Reset in the middle of REQ.
        do_reset(1'b0);
        req = 4'b0100;
        sb_q.push_back(2);
        wait_grant(got, cyc);
        @(negedge clk);
        #1;
        req = '0;
        chk("mid_req_up", {31'b0, xfer_req}, 1);
        rst_ = 1'b0;
        #1;
        chk("async_rst_xfer_req", {31'b0, xfer_req}, 0);
        chk("async_rst_busy", {31'b0, busy}, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_ = 1'b1;
        data_in = 32'h0000_5C00;
        req = 4'b0010;
        sb_q.push_back(1);
        wait_grant(got, cyc);
        @(negedge clk);
        #1;
        req = '0;
        handshake(1, 8'h5C);

        // Far side never acknowledges.
        req = 4'b0001;
        sb_q.push_back(0);
        wait_grant(got, cyc);
        @(negedge clk);
        #1;
        req = '0;
`ifdef HS_TIMEOUT_EN
        cnt = 1;
        while (!err && cnt < 100) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        chk("err_lat", cnt, 17);
        chk("err_xfer_req", {31'b0, xfer_req}, 0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done) cnt++;
        end
        chk("err_no_done", cnt, 0);
        chk("err_back_idle", {31'b0, busy}, 0);
`else
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (!xfer_req || err) cnt++;
        end
        chk("no_timeout_hold", cnt, 0);
        chk("no_timeout_busy", {31'b0, busy}, 1);
`endif

        chk("monitor", mon_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
